display_panel_capture: RTL and testbench
========================================

// Module: display_panel_capture
// PURPOSE
//  Receiving end of the serial latched row/col panel interface that display_driver transmits.
//  Watches rgb/oclk/lat/oe/row, rebuilds each row's shifted bit-planes and counts the '1' latches per
//  pixel channel to recover the PWM-encoded (gamma-corrected) intensity.
//  Emits one pixel write per column for a frame-buffer compare port.
//  Used in loopback benches and on-board self-check; same clk domain as the driver.
// PARAMETERS
//  segments  1   parallel rgb lanes (3 bits each)
//  rows      8   addressable rows
//  columns   32  bits shifted per row per bit-plane
//  bitwidth  8   channel width; a full row is 2**bitwidth latches
// PORTS
//  clk        in   1                      system clock, all logic on posedge
//  rst        in   1                      asynchronous reset, active-high
//  rgb        in   3*segments             panel data; bit 3*i+c = segment i, channel c (c0=R,c1=G,c2=B)
//  oclk       in   1                      panel shift clock (clk-synchronous level)
//  lat        in   1                      panel latch strobe
//  oe         in   1                      panel output enable
//  row        in   $clog2(rows)           panel row address
//  flush      in   1                      one-clk pulse: dump the current row now
//  wr_en      out  1                      wr_row/wr_column/wr_pixel valid this clk
//  wr_row     out  $clog2(rows)           row being dumped
//  wr_column  out  $clog2(columns)        column being dumped
//  wr_pixel   out  3*bitwidth*segments    same packing as the driver pixel input
//  busy       out  1                      dump in progress
//  err_count  out  1                      sticky: lat seen with shift count != columns
//  err_oe     out  1                      sticky: lat rising edge while oe==1
//  err_overrun out 1                      sticky: lat rising edge while busy
// BEHAVIOUR
//  Reset: all outputs 0; shift reg, shift count, counters, prev oclk/lat, acc_row cleared; state IDLE.
//  Edge detect: oclk_q/lat_q register the inputs; rise = in & ~in_q. No sync stage (same domain).
//  Shift: on oclk rise, sr <= {sr, rgb} (new bits enter at LSB end); shift count +1, saturates at columns+1.
//    After N shifts, column c sits at lane slot N-1-c (first-shifted bit = column 0).
//  Latch, on lat rise (IDLE only):
//    - err_count <= 1 if shift count != columns; err_oe <= 1 if oe.
//    - Each column/segment/channel counter (bitwidth+1 bits) increments where its sr bit is 1,
//      saturating at 2**bitwidth.
//    - Shift count <= 0.
//  oclk rise and lat rise in the same clk: the shift applies first, then the latch uses the updated sr.
//  Row tracking: acc_row holds the row being accumulated. In IDLE, if row != acc_row, or flush==1:
//    go to DUMP for acc_row, then acc_row <= row. flush with row unchanged dumps and stays on that row.
//  FSM IDLE -> DUMP -> CLEAR -> IDLE
//    DUMP: one column per clk for columns clks, column 0 first.
//      wr_en=1; wr_row=acc_row; wr_column=index;
//      channel value = min(count, 2**bitwidth-1) truncated to bitwidth.
//    CLEAR: 1 clk; zero all counters; wr_en=0.
//    busy=1 in DUMP and CLEAR.
//  Latency: first wr_en is 1 clk after the row change / flush is sampled; the dump lasts columns+1 clks.
//  While busy:
//    - oclk shifts still apply.
//    - lat rise sets err_overrun, and the latch is dropped (counters untouched).
//    - Further row changes and flush are ignored until IDLE; a pending row mismatch then re-triggers.
//  Reset mid-dump: immediate return to IDLE, counters cleared, no further writes.
//  Output is the corrected (post-encoder) value, not the raw frame pixel.
// TESTING
//  1) columns=4, bitwidth=2: 4 latches of planes ch R = 1,1,1,0 on col 2, then row 0->1
//     -> 4 writes row 0; col2 R=3, other channels 0; no errors.
//  2) All-ones for 2**bitwidth latches -> counter reaches 256, reported 255; a 257th latch leaves it at 255.
//  3) Only 3 oclk pulses before lat (columns=4) -> err_count=1, stays 1 until rst.
//  4) lat rise with oe=1 -> err_oe=1; lat rise during DUMP -> err_overrun=1, counters unchanged.
//  5) Loopback to display_driver with a known frame -> every wr_pixel equals the encoder's cpixel for
//     every row/column; frame_complete is seen once per rows dumps (flush after last row).
//  6) Assert rst mid-DUMP at column 1 -> wr_en=0 the next clk; the next dump reports all zeros.

Source files
------------

// File: rtl/display_panel_capture.sv
// Panel-interface capture: rebuilds bit-planes shifted on rgb/oclk, counts
// the '1' latches per column/segment/channel to recover the PWM intensity,
// and dumps one pixel per column when the row address changes or on flush.
module display_panel_capture #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3*segments-1:0]            rgb,
  input  logic                             oclk,
  input  logic                             lat,
  input  logic                             oe,
  input  logic [$clog2(rows)-1:0]          row,
  input  logic                             flush,
  output logic                             wr_en,
  output logic [$clog2(rows)-1:0]          wr_row,
  output logic [$clog2(columns)-1:0]       wr_column,
  output logic [3*bitwidth*segments-1:0]   wr_pixel,
  output logic                             busy,
  output logic                             err_count,
  output logic                             err_oe,
  output logic                             err_overrun
);

  localparam int LANES = 3 * segments;
  localparam int SR_W  = LANES * columns;
  localparam int SC_W  = $clog2(columns + 2);
  localparam int CNT_W = bitwidth + 1;
  localparam int RW    = $clog2(rows);
  localparam int CW    = $clog2(columns);
  localparam int PIX_W = 3 * bitwidth * segments;

  // A counter can only exceed the channel maximum by reaching exactly 2**bitwidth.
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {bitwidth{1'b0}}};

  typedef enum logic [1:0] {IDLE, DUMP, CLEAR} state_t;

  state_t               state;
  logic [CW-1:0]        idx;
  logic [RW-1:0]        acc_row;
  logic                 oclk_q;
  logic                 lat_q;
  logic [SR_W-1:0]      sr;
  logic [SR_W-1:0]      sr_nx;
  logic [SC_W-1:0]      sh_cnt;
  logic [SC_W-1:0]      sh_cnt_nx;
  logic [CNT_W-1:0]     cnt [columns][LANES];
  logic                 oclk_rise;
  logic                 lat_rise;
  logic                 lat_acc;
  logic [CW-1:0]        col_sel;
  logic [PIX_W-1:0]     pix_sel;

  // Clamp a latch count to the channel range (2**bitwidth reads as all ones).
  function automatic logic [bitwidth-1:0] sat_chan(input logic [CNT_W-1:0] v);
    return v[bitwidth] ? {bitwidth{1'b1}} : v[bitwidth-1:0];
  endfunction

  assign oclk_rise = oclk & ~oclk_q;
  assign lat_rise  = lat & ~lat_q;
  assign lat_acc   = lat_rise && (state == IDLE);

  // Post-shift view of the shift register and shift count, so a latch in the
  // same clk as a shift sees the freshly shifted bits.
  always_comb begin
    sr_nx     = sr;
    sh_cnt_nx = sh_cnt;
    if (oclk_rise) begin
      sr_nx = SR_W'({sr, rgb});
      if (sh_cnt != SC_W'(columns + 1)) sh_cnt_nx = sh_cnt + 1'b1;
    end
  end

  // Column whose pixel is loaded into the write registers at the next edge.
  always_comb begin
    col_sel = '0;
    if (state == DUMP && idx != CW'(columns - 1)) col_sel = idx + 1'b1;
    pix_sel = '0;
    for (int k = 0; k < LANES; k++)
      pix_sel[k*bitwidth +: bitwidth] = sat_chan(cnt[col_sel][k]);
  end

  // Edge-detect history, shift register and shift count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oclk_q <= 1'b0;
      lat_q  <= 1'b0;
      sr     <= '0;
      sh_cnt <= '0;
    end else begin
      oclk_q <= oclk;
      lat_q  <= lat;
      sr     <= sr_nx;
      sh_cnt <= lat_acc ? '0 : sh_cnt_nx;
    end
  end

  // Per column/lane latch counters; cleared after each dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < columns; c++)
        for (int k = 0; k < LANES; k++) cnt[c][k] <= '0;
    end else if (state == CLEAR) begin
      for (int c = 0; c < columns; c++)
        for (int k = 0; k < LANES; k++) cnt[c][k] <= '0;
    end else if (lat_acc) begin
      for (int c = 0; c < columns; c++)
        for (int k = 0; k < LANES; k++)
          if (sr_nx[(columns-1-c)*LANES + k] && cnt[c][k] != CNT_MAX)
            cnt[c][k] <= cnt[c][k] + 1'b1;
    end
  end

  // Sticky protocol error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count   <= 1'b0;
      err_oe      <= 1'b0;
      err_overrun <= 1'b0;
    end else if (lat_rise) begin
      if (state == IDLE) begin
        if (sh_cnt_nx != SC_W'(columns)) err_count <= 1'b1;
        if (oe) err_oe <= 1'b1;
      end else begin
        err_overrun <= 1'b1;
      end
    end
  end

  // Dump FSM with registered write port: one column per clk, then a clear clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc_row   <= '0;
      wr_en     <= 1'b0;
      wr_row    <= '0;
      wr_column <= '0;
      wr_pixel  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (row != acc_row || flush) begin
            state     <= DUMP;
            idx       <= '0;
            wr_en     <= 1'b1;
            wr_row    <= acc_row;
            wr_column <= '0;
            wr_pixel  <= pix_sel;
            busy      <= 1'b1;
            acc_row   <= row;
          end
        end
        DUMP: begin
          if (idx == CW'(columns - 1)) begin
            state <= CLEAR;
            wr_en <= 1'b0;
          end else begin
            idx       <= idx + 1'b1;
            wr_column <= idx + 1'b1;
            wr_pixel  <= pix_sel;
          end
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          wr_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_panel_capture.sv
// Bench for display_panel_capture: directed and randomized bit-plane traffic
// against a queue/array model of the panel capture rules.
module tb_display_panel_capture;

  localparam int SEG  = 2;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int BW   = 8;
  localparam int L    = 3 * SEG;
  localparam int PW   = 3 * BW * SEG;

  logic            clk = 1'b0;
  logic            rst;
  logic [L-1:0]    rgb;
  logic            oclk, lat, oe, flush;
  logic [1:0]      row;
  logic            wr_en;
  logic [1:0]      wr_row;
  logic [1:0]      wr_column;
  logic [PW-1:0]   wr_pixel;
  logic            busy, err_count, err_oe, err_overrun;

  display_panel_capture #(.segments(SEG), .rows(ROWS), .columns(COLS), .bitwidth(BW)) dut (
    .clk(clk), .rst(rst), .rgb(rgb), .oclk(oclk), .lat(lat), .oe(oe), .row(row),
    .flush(flush), .wr_en(wr_en), .wr_row(wr_row), .wr_column(wr_column),
    .wr_pixel(wr_pixel), .busy(busy), .err_count(err_count), .err_oe(err_oe),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [L-1:0] hist[$];          // shifted words, newest first
  int           mcnt[COLS][L];
  int           msh;
  bit           m_ec, m_eo, m_ov;
  int           m_acc_row;
  logic [PW-1:0] cap[COLS];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] exp_pix(input int c);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < L; k++)
      p[k*BW +: BW] = BW'((mcnt[c][k] > 255) ? 255 : mcnt[c][k]);
    return p;
  endfunction

  task automatic m_push(input logic [L-1:0] w);
    hist.push_front(w);
    if (hist.size() > COLS) void'(hist.pop_back());
    if (msh < COLS + 1) msh++;
  endtask

  task automatic m_latch(input bit oev);
    logic [L-1:0] w;
    if (msh != COLS) m_ec = 1'b1;
    if (oev) m_eo = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      w = (hist.size() > COLS - 1 - c) ? hist[COLS-1-c] : '0;
      for (int k = 0; k < L; k++)
        if (w[k] && mcnt[c][k] < 256) mcnt[c][k]++;
    end
    msh = 0;
  endtask

  task automatic m_clear_counts;
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < L; k++) mcnt[c][k] = 0;
  endtask

  task automatic m_reset;
    hist.delete();
    m_clear_counts();
    msh = 0; m_ec = 0; m_eo = 0; m_ov = 0; m_acc_row = 0;
  endtask

  task automatic shift(input logic [L-1:0] w);
    rgb = w; oclk = 1'b1; tick;
    oclk = 1'b0; tick;
    m_push(w);
  endtask

  task automatic latch(input bit oev);
    oe = oev; lat = 1'b1; tick;
    lat = 1'b0; oe = 1'b0; tick;
    m_latch(oev);
  endtask

  task automatic shift_latch(input logic [L-1:0] w);
    rgb = w; oclk = 1'b1; lat = 1'b1; tick;
    oclk = 1'b0; lat = 1'b0; tick;
    m_push(w);
    m_latch(1'b0);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_err_count"}, 64'(err_count), 64'(m_ec));
    chk({tag, "_err_oe"}, 64'(err_oe), 64'(m_eo));
    chk({tag, "_err_overrun"}, 64'(err_overrun), 64'(m_ov));
  endtask

  // mode 0: plain dump, 1: oclk+lat pulse during dump, 2: reset at column 1
  task automatic do_dump(input bit use_flush, input int target, input int mode);
    int exp_row, nr;
    logic [L-1:0] w;
    exp_row = m_acc_row;
    if (use_flush) flush = 1'b1;
    else begin
      nr = (target >= 0) ? target : (m_acc_row + 1 + $urandom_range(0, 2)) % ROWS;
      row = nr[1:0];
      m_acc_row = nr;
    end
    tick;
    flush = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      chk("dump_wr_en", 64'(wr_en), 64'd1);
      chk("dump_wr_row", 64'(wr_row), 64'(exp_row));
      chk("dump_wr_column", 64'(wr_column), 64'(c));
      chk("dump_wr_pixel", 64'(wr_pixel), 64'(exp_pix(c)));
      chk("dump_busy", 64'(busy), 64'd1);
      cap[c] = wr_pixel;
      if (mode == 2 && c == 1) begin
        rst = 1'b1; row = 2'd0;
        m_reset();
        tick;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        return;
      end
      if (mode == 1 && c == 1) begin
        w = L'($urandom);
        rgb = w; oclk = 1'b1; lat = 1'b1;
        m_push(w);
        m_ov = 1'b1;
      end
      if (mode == 1 && c == 2) begin
        oclk = 1'b0; lat = 1'b0;
      end
      tick;
    end
    chk("clear_wr_en", 64'(wr_en), 64'd0);
    chk("clear_busy", 64'(busy), 64'd1);
    tick;
    chk("idle_busy", 64'(busy), 64'd0);
    m_clear_counts();
  endtask

  task automatic rand_latches(input int n);
    logic [L-1:0] w;
    bit combined;
    for (int i = 0; i < n; i++) begin
      combined = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        w = L'($urandom);
        if (c == COLS - 1 && $urandom_range(0, 2) == 0) begin
          shift_latch(w);
          combined = 1'b1;
        end else shift(w);
      end
      if (!combined) latch(1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rgb = '0; oclk = 1'b0; lat = 1'b0; oe = 1'b0; flush = 1'b0; row = 2'd0;
    m_reset();
    tick; tick;
    rst = 1'b0;
    tick;

    // Reset state
    chk("rst_wr_en0", 64'(wr_en), 64'd0);
    chk("rst_busy0", 64'(busy), 64'd0);
    chk("rst_wr_pixel0", 64'(wr_pixel), 64'd0);
    chk("rst_wr_row0", 64'(wr_row), 64'd0);
    chk("rst_wr_column0", 64'(wr_column), 64'd0);
    chk_flags("rst");

    // Planes R = 1,1,1,0 on column 2, then row 0 -> 1
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < COLS; c++) shift((c == 2 && p < 3) ? L'(1) : L'(0));
      latch(1'b0);
    end
    do_dump(1'b0, 1, 0);
    chk("t1_col0", 64'(cap[0]), 64'd0);
    chk("t1_col2_R3", 64'(cap[2]), 64'h3);
    chk("t1_col3", 64'(cap[3]), 64'd0);
    chk_flags("t1");

    // Randomized rows
    for (int it = 0; it < 8; it++) begin
      rand_latches($urandom_range(1, 5));
      do_dump(1'($urandom_range(0, 1)), -1, 0);
      chk_flags("rand");
    end

    // Saturation: 256 and then 257 all-ones latches read back as 255
    rand_latches(0);
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < COLS; c++) shift('1);
      latch(1'b0);
    end
    do_dump(1'b1, -1, 0);
    chk("sat256_col0", 64'(cap[0]), 64'hFFFF_FFFF_FFFF);
    chk("sat256_col3", 64'(cap[3]), 64'hFFFF_FFFF_FFFF);
    for (int i = 0; i < 257; i++) begin
      for (int c = 0; c < COLS; c++) shift('1);
      latch(1'b0);
    end
    do_dump(1'b0, -1, 0);
    chk("sat257_col1", 64'(cap[1]), 64'hFFFF_FFFF_FFFF);
    chk_flags("sat");

    // Overrun: lat rise and shift during a dump
    rand_latches(3);
    do_dump(1'b0, -1, 1);
    chk("ovr_flag", 64'(err_overrun), 64'd1);
    chk_flags("ovr");

    // Output-enable error: full row of shifts then latch with oe=1
    for (int c = 0; c < COLS; c++) shift(L'($urandom));
    latch(1'b1);
    chk("oe_flag", 64'(err_oe), 64'd1);
    chk_flags("oe");

    // Short row: 3 shifts then latch
    rand_latches(1);
    for (int c = 0; c < 3; c++) shift(L'($urandom));
    latch(1'b0);
    chk("cnt_flag", 64'(err_count), 64'd1);
    rand_latches(2);
    do_dump(1'b1, -1, 0);
    chk("cnt_sticky", 64'(err_count), 64'd1);
    chk_flags("cnt");

    // Reset mid-dump, then a flush dump reports zeros
    rand_latches(3);
    do_dump(1'b0, -1, 2);
    chk_flags("rstmid");
    tick;
    do_dump(1'b1, -1, 0);
    chk("post_rst_col0", 64'(cap[0]), 64'd0);
    chk("post_rst_col3", 64'(cap[3]), 64'd0);

    // More random traffic after reset
    for (int it = 0; it < 4; it++) begin
      rand_latches($urandom_range(1, 4));
      do_dump(1'($urandom_range(0, 1)), -1, 0);
      chk_flags("rand2");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
